// File: rtl/uno_deck_pool.sv
// UNO deck pool: draw pile plus discard pile, LFSR-driven Fisher-Yates shuffle,
// burst draws with automatic discard recycling when the draw pile runs dry.
module uno_deck_pool #(
  parameter int CARD_W    = 6,
  parameter int DECK_SIZE = 108,
  parameter int IDX_W     = 7,
  parameter int LFSR_W    = 16,
  parameter int MAX_DRAW  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_draw_req,
  input  logic [2:0]        i_draw_num,
  output logic              o_card_valid,
  output logic [CARD_W-1:0] o_card,
  output logic              o_draw_done,
  output logic              o_short,
  input  logic              i_disc_valid,
  input  logic [CARD_W-1:0] i_disc_card,
  output logic              o_disc_ready,
  output logic              o_ready,
  output logic [IDX_W-1:0]  o_draw_cnt,
  output logic [IDX_W-1:0]  o_disc_cnt,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    S_FILL    = 3'd0,
    S_SEED    = 3'd1,
    S_SHUFFLE = 3'd2,
    S_READY   = 3'd3,
    S_DRAW    = 3'd4,
    S_RECYCLE = 3'd5
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_W'(16'hB400) : LFSR_W'(16'h0000));
  endfunction

  state_t              r_state;
  state_t              r_ret;
  logic [CARD_W-1:0]   r_draw [0:DECK_SIZE-1];
  logic [CARD_W-1:0]   r_disc [0:DECK_SIZE-1];
  logic [IDX_W-1:0]    r_draw_cnt;
  logic [IDX_W-1:0]    r_disc_cnt;
  logic [IDX_W-1:0]    r_j;
  logic [IDX_W-1:0]    r_k;
  logic [IDX_W-1:0]    r_fill;
  logic [4:0]          r_fill_off;
  logic [1:0]          r_fill_col;
  logic [LFSR_W-1:0]   r_free;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [2:0]          r_n;
  logic                r_card_valid;
  logic [CARD_W-1:0]   r_card;
  logic                r_draw_done;
  logic                r_short;

  logic [IDX_W-1:0]    w_r;
  logic [CARD_W-1:0]   w_card_j;
  logic [CARD_W-1:0]   w_card_r;
  logic [CARD_W-1:0]   w_card_top;
  logic [3:0]          w_fill_val;
  logic [CARD_W-1:0]   w_fill_card;
  logic [LFSR_W-1:0]   w_seed_raw;
  logic [LFSR_W-1:0]   w_seed;
  logic [IDX_W-1:0]    w_j_start;
  logic                w_fill_we;
  logic                w_swap_we;
  logic                w_copy_we;
  logic                w_disc_room;
  logic                w_disc_we;
  logic                w_num_ok;

  assign w_r         = r_lfsr[IDX_W-1:0];
  assign w_card_j    = r_draw[r_j];
  assign w_card_r    = r_draw[w_r];
  assign w_card_top  = r_draw[r_draw_cnt - IDX_W'(1)];
  assign w_seed_raw  = r_free ^ LFSR_W'(16'hACE1);
  assign w_seed      = (w_seed_raw == '0) ? LFSR_W'(1) : w_seed_raw;
  assign w_j_start   = (r_draw_cnt == '0) ? '0 : (r_draw_cnt - IDX_W'(1));
  assign w_fill_we   = (r_state == S_FILL);
  assign w_swap_we   = (r_state == S_SHUFFLE) && (r_j != '0) && (w_r <= r_j);
  assign w_copy_we   = (r_state == S_RECYCLE);
  assign w_disc_room = (r_disc_cnt < IDX_W'(DECK_SIZE));
  assign w_disc_we   = (r_state == S_READY) && i_disc_valid && w_disc_room;
  assign w_num_ok    = (i_draw_num != 3'd0) && (i_draw_num <= 3'(MAX_DRAW));

  // Fill card for the current slot: offset 0 -> 0, 1..24 -> pairs of 1..12, then wilds.
  always_comb begin
    w_fill_val  = 4'd0;
    w_fill_card = '0;
    if (r_fill_off == 5'd0) begin
      w_fill_val = 4'd0;
    end else if (r_fill_off <= 5'd24) begin
      w_fill_val = r_fill_off[4:1] + {3'b000, r_fill_off[0]};
    end else if (r_fill_off == 5'd25) begin
      w_fill_val = 4'd13;
    end else begin
      w_fill_val = 4'd14;
    end
    w_fill_card[CARD_W-1:CARD_W-2] = r_fill_col;
    w_fill_card[3:0]               = w_fill_val;
  end

  // Pile storage writes: fill, shuffle swap, recycle copy, discard append.
  always_ff @(posedge i_clk) begin
    if (w_fill_we) r_draw[r_fill] <= w_fill_card;
    if (w_swap_we) begin
      r_draw[r_j] <= w_card_r;
      r_draw[w_r] <= w_card_j;
    end
    if (w_copy_we) r_draw[r_k] <= r_disc[r_k];
    if (w_disc_we) r_disc[r_disc_cnt] <= i_disc_card;
  end

  // Control FSM, counters, LFSR and registered card outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_FILL;
      r_ret        <= S_READY;
      r_draw_cnt   <= '0;
      r_disc_cnt   <= '0;
      r_j          <= '0;
      r_k          <= '0;
      r_fill       <= '0;
      r_fill_off   <= 5'd0;
      r_fill_col   <= 2'd0;
      r_free       <= '0;
      r_lfsr       <= '0;
      r_n          <= 3'd0;
      r_card_valid <= 1'b0;
      r_card       <= '0;
      r_draw_done  <= 1'b0;
      r_short      <= 1'b0;
    end else begin
      r_card_valid <= 1'b0;
      r_draw_done  <= 1'b0;
      r_short      <= 1'b0;
      if ((r_state != S_FILL) && (r_state != S_SEED)) r_lfsr <= lfsr_step(r_lfsr);
      case (r_state)
        S_FILL: begin
          if (r_fill_off == 5'd26) begin
            r_fill_off <= 5'd0;
            r_fill_col <= r_fill_col + 2'd1;
          end else begin
            r_fill_off <= r_fill_off + 5'd1;
          end
          if (r_fill == IDX_W'(DECK_SIZE - 1)) begin
            r_fill     <= '0;
            r_draw_cnt <= IDX_W'(DECK_SIZE);
            r_state    <= S_SEED;
          end else begin
            r_fill <= r_fill + IDX_W'(1);
          end
        end
        S_SEED: begin
          r_free <= r_free + LFSR_W'(1);
          if (i_start) begin
            r_lfsr  <= w_seed;
            r_j     <= w_j_start;
            r_ret   <= S_READY;
            r_state <= S_SHUFFLE;
          end
        end
        S_SHUFFLE: begin
          if (r_j == '0) begin
            r_state <= r_ret;
          end else if (w_r <= r_j) begin
            r_j <= r_j - IDX_W'(1);
          end
        end
        S_READY: begin
          if (w_disc_we) r_disc_cnt <= r_disc_cnt + IDX_W'(1);
          if (i_draw_req && w_num_ok) begin
            r_n     <= i_draw_num;
            r_state <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (r_draw_cnt != '0) begin
            r_card_valid <= 1'b1;
            r_card       <= w_card_top;
            r_draw_cnt   <= r_draw_cnt - IDX_W'(1);
            r_n          <= r_n - 3'd1;
            if (r_n == 3'd1) begin
              r_draw_done <= 1'b1;
              r_state     <= S_READY;
            end
          end else if (r_disc_cnt != '0) begin
            r_k     <= '0;
            r_state <= S_RECYCLE;
          end else begin
            r_draw_done <= 1'b1;
            r_short     <= 1'b1;
            r_state     <= S_READY;
          end
        end
        S_RECYCLE: begin
          if (r_k == (r_disc_cnt - IDX_W'(1))) begin
            r_draw_cnt <= r_disc_cnt;
            r_disc_cnt <= '0;
            r_j        <= r_disc_cnt - IDX_W'(1);
            r_ret      <= S_DRAW;
            r_state    <= S_SHUFFLE;
          end else begin
            r_k <= r_k + IDX_W'(1);
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign o_card_valid = r_card_valid;
  assign o_card       = r_card;
  assign o_draw_done  = r_draw_done;
  assign o_short      = r_short;
  assign o_ready      = (r_state == S_READY);
  assign o_disc_ready = (r_state == S_READY) && w_disc_room;
  assign o_draw_cnt   = r_draw_cnt;
  assign o_disc_cnt   = r_disc_cnt;
  assign o_state      = r_state;

endmodule

// File: doc/uno_deck_pool.md
Name: uno_deck_pool

Overview:
- Parametrised successor of the UNO card deck: a single draw pile plus a discard pile, with a Fisher-Yates shuffle driven by a seeded LFSR.
- Multi-card draw bursts use a valid/done handshake. When the draw pile empties mid-burst, the discard pile is recycled and reshuffled automatically.
- Sits between the game controller (draw requests, played-card returns) and the player-hand blocks that receive the drawn cards.

Parameters:
CARD_W, 6, card encoding width: [CARD_W-1:CARD_W-2] colour (0 red, 1 yellow, 2 green, 3 blue), [3:0] value (0-9, 10 skip, 11 reverse, 12 draw two, 13 wild, 14 wild draw four)
DECK_SIZE, 108, total cards; must be 27*k with k≥1; each group of 27 is one colour set
IDX_W, 7, index/count width; 2^IDX_W ≥ DECK_SIZE+1
LFSR_W, 16, LFSR width
MAX_DRAW, 4, largest burst accepted by one request

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle pulse: seed LFSR and begin shuffle
i_draw_req  in  1  draw request; sampled only while o_ready=1
i_draw_num  in  3  cards to draw, 1..MAX_DRAW
o_card_valid  out  1  o_card holds a drawn card this cycle
o_card  out  CARD_W  drawn card
o_draw_done  out  1  one-cycle pulse at end of burst
o_short  out  1  valid with o_draw_done: burst ended early, both piles empty
i_disc_valid  in  1  return a played card to the discard pile
i_disc_card  in  CARD_W  card returned
o_disc_ready  out  1  discard pile accepts a card this cycle
o_ready  out  1  idle; new draw request may be issued
o_draw_cnt  out  IDX_W  cards in draw pile
o_disc_cnt  out  IDX_W  cards in discard pile
o_state  out  3  FSM state for debug

Behaviour:
- Reset:
  - state S_FILL, counts 0, LFSR 0, fill counter 0, free-running counter 0.
  - All outputs 0 except o_state=S_FILL.
  - Reset mid-operation discards everything and restarts from S_FILL.
- S_FILL:
  - Writes draw[i] one card per cycle, i = 0..DECK_SIZE-1.
  - Within each 27-card group g: colour g mod 4; offsets 0 → value 0; 1..24 → value 1+(offset-1)/2 (two each of 1..12); 25 → 13; 26 → 14.
  - After the last write: o_draw_cnt=DECK_SIZE, go to S_SEED. i_start is ignored during fill.
- S_SEED:
  - Free-running counter increments every cycle.
  - On i_start: LFSR ← counter XOR 16'hACE1; if the result is 0, use 1.
  - Set j ← o_draw_cnt-1, go to S_SHUFFLE.
- LFSR:
  - Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). Steps every cycle except in S_FILL and S_SEED.
  - r = LFSR[IDX_W-1:0].
- S_SHUFFLE (one swap attempt per cycle):
  - If r > j: reject, retry next cycle.
  - Otherwise swap draw[j] and draw[r], then j ← j-1.
  - When j reaches 0: go to S_READY if entered from reset or start, or back to S_DRAW if entered from a recycle.
  - Counts with j=0 at entry (≤1 card) skip straight to the exit.
- S_READY:
  - o_ready=1 and o_disc_ready = (o_disc_cnt < DECK_SIZE).
  - Discard accept writes disc[o_disc_cnt] and increments the count. i_disc_valid while not ready is dropped.
  - i_draw_req with i_draw_num in 1..MAX_DRAW: latch the remaining count n, go to S_DRAW. Other values are ignored.
  - Simultaneous discard and draw request: the discard is accepted first in the same cycle, and the draw begins next cycle.
- S_DRAW (per cycle):
  - If o_draw_cnt>0: o_card_valid=1, o_card=draw[o_draw_cnt-1], decrement o_draw_cnt and n.
    - When n becomes 0: pulse o_draw_done with the last card, go to S_READY.
  - If o_draw_cnt=0 and o_disc_cnt>0: go to S_RECYCLE, k ← 0.
  - If both counts are 0: o_draw_done=1, o_short=1, go to S_READY.
  - Cards are emitted on consecutive cycles except across a recycle.
- S_RECYCLE:
  - Copies draw[k] ← disc[k], one per cycle.
  - When done: o_draw_cnt ← old o_disc_cnt, o_disc_cnt ← 0, j ← count-1, go to S_SHUFFLE with return target S_DRAW.
- The card total is conserved: draw + discard + cards held outside = DECK_SIZE. The block does not check duplicates.

Test Plan:
- Reset then 108 idle cycles → o_draw_cnt=108, o_state=S_SEED; i_start with counter forced to 0 → seed 16'hACE1; S_READY reached; dump draw pile: histogram matches 4 colours × 27 (value 0 ×1, 1..12 ×2, 13 ×1, 14 ×1).
- From S_READY, draw 4 → 4 consecutive o_card_valid cycles, o_draw_done on the 4th, o_draw_cnt=104, cards equal draw[107..104] top-down.
- Discard 3 cards, draw until the pile holds 1, then draw 2 → 1 card, recycle (3 copy cycles), shuffle, 1 card, done; o_disc_cnt=0, o_draw_cnt=2.
- Both piles empty, draw 2 → no o_card_valid; o_draw_done=1 and o_short=1 in the same cycle; back to S_READY.
- i_disc_valid and i_draw_req in the same S_READY cycle → o_disc_cnt increments; first card appears 2 cycles later.
- Assert i_rst_n low during S_SHUFFLE → all outputs 0 immediately (async); after release, o_state=S_FILL and refill completes in 108 cycles.
